// File: rtl/fetch_hazard_ctrl.sv
// Fetch-stage hazard controller: scoreboard-based RAW/WAW stall with a single
// registered issue slot, flush, backpressure hold and a saturating stall counter.
module fetch_hazard_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inst_valid_in,
    output logic        inst_ready_out,
    input  logic [4:0]  opcode_in,
    input  logic [3:0]  s1_in,
    input  logic [3:0]  s2_in,
    input  logic [3:0]  dest_in,
    input  logic [31:0] ime_data_in,
    output logic        issue_valid,
    input  logic        issue_ready,
    output logic [4:0]  opcode_out,
    output logic [3:0]  s1_out,
    output logic [3:0]  s2_out,
    output logic [3:0]  dest_out,
    output logic [31:0] ime_data_out,
    input  logic        wb_valid,
    input  logic [3:0]  wb_dest,
    input  logic        flush,
    output logic [15:0] busy_map,
    output logic [15:0] stall_cnt
);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_HOLD  = 2'd1;
    localparam logic [1:0] ST_STALL = 2'd2;

    function automatic logic f_reads_s2(input logic [4:0] op);
        case (op)
            5'd2, 5'd3, 5'd4, 5'd5, 5'd24, 5'd26, 5'd28, 5'd30: f_reads_s2 = 1'b1;
            default:                                            f_reads_s2 = 1'b0;
        endcase
    endfunction

    function automatic logic f_reads_s1(input logic [4:0] op);
        f_reads_s1 = (op == 5'd1) || (op >= 5'd6 && op <= 5'd11) ||
                     (op == 5'd27) || f_reads_s2(op);
    endfunction

    function automatic logic f_writes(input logic [4:0] op);
        f_writes = (op >= 5'd1) && (op <= 5'd11);
    endfunction

    logic        r_issue_valid;
    logic [4:0]  r_opcode;
    logic [3:0]  r_s1;
    logic [3:0]  r_s2;
    logic [3:0]  r_dest;
    logic [31:0] r_imm;
    logic [15:0] r_busy;
    logic [15:0] r_stall_cnt;
    logic [1:0]  r_state;

    logic        w_rd_s1;
    logic        w_rd_s2;
    logic        w_wr;
    logic        w_hazard;
    logic        w_ready;
    logic        w_accept;
    logic        w_issue_valid_nxt;
    logic [15:0] w_busy_nxt;
    logic [1:0]  w_state_nxt;

    // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        w_rd_s1  = f_reads_s1(opcode_in);
        w_rd_s2  = f_reads_s2(opcode_in);
        w_wr     = f_writes(opcode_in);
        w_hazard = inst_valid_in &
                   ((w_rd_s1 & r_busy[s1_in]) |
                    (w_rd_s2 & r_busy[s2_in]) |
                    (w_wr    & r_busy[dest_in]));
        w_ready  = ~w_hazard & ~flush & (~r_issue_valid | issue_ready);
        w_accept = inst_valid_in & w_ready;

        w_issue_valid_nxt = r_issue_valid;
        if (flush)            w_issue_valid_nxt = 1'b0;
        else if (w_accept)    w_issue_valid_nxt = 1'b1;
        else if (issue_ready) w_issue_valid_nxt = 1'b0;

        // The set is applied after the clear so a same-register collision leaves the bit set.
        w_busy_nxt = r_busy;
        if (wb_valid)          w_busy_nxt[wb_dest] = 1'b0;
        if (w_accept && w_wr)  w_busy_nxt[dest_in] = 1'b1;

        w_state_nxt = ST_RUN;
        if (flush)                                  w_state_nxt = ST_RUN;
        else if (inst_valid_in && w_hazard)         w_state_nxt = ST_STALL;
        else if (w_issue_valid_nxt && !issue_ready) w_state_nxt = ST_HOLD;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_issue_valid <= 1'b0;
            r_opcode      <= '0;
            r_s1          <= '0;
            r_s2          <= '0;
            r_dest        <= '0;
            r_imm         <= '0;
            r_busy        <= '0;
            r_stall_cnt   <= '0;
            r_state       <= ST_RUN;
        end else begin
            r_issue_valid <= w_issue_valid_nxt;
            r_busy        <= w_busy_nxt;
            r_state       <= w_state_nxt;
            if (w_accept) begin
                r_opcode <= opcode_in;
                r_s1     <= w_rd_s1 ? s1_in : 4'd0;
                r_s2     <= w_rd_s2 ? s2_in : 4'd0;
                r_dest   <= dest_in;
                r_imm    <= ime_data_in;
            end
            if (r_state == ST_STALL && r_stall_cnt != 16'hFFFF)
                r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign inst_ready_out = w_ready;
    assign issue_valid    = r_issue_valid;
    assign opcode_out     = r_opcode;
    assign s1_out         = r_s1;
    assign s2_out         = r_s2;
    assign dest_out       = r_dest;
    assign ime_data_out   = r_imm;
    assign busy_map       = r_busy;
    assign stall_cnt      = r_stall_cnt;

endmodule

// File: tb/tb_fetch_hazard_ctrl.sv
// Self-checking bench for fetch_hazard_ctrl: directed scenarios plus random traffic
// compared cycle by cycle against a rule-level reference model.
module tb_fetch_hazard_ctrl;

    localparam int M_RUN   = 0;
    localparam int M_HOLD  = 1;
    localparam int M_STALL = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        inst_valid_in = 1'b0;
    logic        inst_ready_out;
    logic [4:0]  opcode_in = '0;
    logic [3:0]  s1_in = '0, s2_in = '0, dest_in = '0;
    logic [31:0] ime_data_in = '0;
    logic        issue_valid;
    logic        issue_ready = 1'b1;
    logic [4:0]  opcode_out;
    logic [3:0]  s1_out, s2_out, dest_out;
    logic [31:0] ime_data_out;
    logic        wb_valid = 1'b0;
    logic [3:0]  wb_dest = '0;
    logic        flush = 1'b0;
    logic [15:0] busy_map;
    logic [15:0] stall_cnt;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    bit          m_busy [16];
    bit          m_iv;
    int          m_op, m_s1, m_s2, m_dest;
    logic [31:0] m_imm;
    int          m_state;
    int          m_cnt;
    bit          m_hz, m_rdy, m_acc;

    always #5 clk = ~clk;

    fetch_hazard_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .inst_valid_in(inst_valid_in), .inst_ready_out(inst_ready_out),
        .opcode_in(opcode_in), .s1_in(s1_in), .s2_in(s2_in), .dest_in(dest_in),
        .ime_data_in(ime_data_in),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .opcode_out(opcode_out), .s1_out(s1_out), .s2_out(s2_out), .dest_out(dest_out),
        .ime_data_out(ime_data_out),
        .wb_valid(wb_valid), .wb_dest(wb_dest), .flush(flush),
        .busy_map(busy_map), .stall_cnt(stall_cnt)
    );

    function automatic bit reads_s1(int op);
        return op inside {1, [2:5], [6:11], 24, 26, 27, 28, 30};
    endfunction
    function automatic bit reads_s2(int op);
        return op inside {[2:5], 24, 26, 28, 30};
    endfunction
    function automatic bit writes(int op);
        return op inside {[1:11]};
    endfunction

    function automatic logic [15:0] busy_vec();
        logic [15:0] v;
        for (int i = 0; i < 16; i++) v[i] = m_busy[i];
        return v;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_busy[i] = 1'b0;
        m_iv = 0; m_op = 0; m_s1 = 0; m_s2 = 0; m_dest = 0; m_imm = '0;
        m_state = M_RUN; m_cnt = 0;
    endtask

    task automatic check_regs();
        check("issue_valid", {31'd0, issue_valid}, {31'd0, m_iv});
        check("opcode_out", {27'd0, opcode_out}, m_op);
        check("s1_out", {28'd0, s1_out}, m_s1);
        check("s2_out", {28'd0, s2_out}, m_s2);
        check("dest_out", {28'd0, dest_out}, m_dest);
        check("ime_data_out", ime_data_out, m_imm);
        check("busy_map", {16'd0, busy_map}, {16'd0, busy_vec()});
        check("stall_cnt", {16'd0, stall_cnt}, m_cnt);
    endtask

    // One clock: compare the combinational ready, advance the model, compare registers.
    task automatic cycle(input bit chk);
        bit nxt_iv;
        int op;
        op = int'(opcode_in);
        #1;
        m_hz  = inst_valid_in && ((reads_s1(op) && m_busy[s1_in]) ||
                                  (reads_s2(op) && m_busy[s2_in]) ||
                                  (writes(op)   && m_busy[dest_in]));
        m_rdy = !m_hz && !flush && (!m_iv || issue_ready);
        m_acc = inst_valid_in && m_rdy;
        if (chk) check("inst_ready_out", {31'd0, inst_ready_out}, {31'd0, m_rdy});
        nxt_iv = flush ? 1'b0 : m_acc ? 1'b1 : issue_ready ? 1'b0 : m_iv;
        @(posedge clk);
        if (m_state == M_STALL && m_cnt < 65535) m_cnt++;
        if (flush)                      m_state = M_RUN;
        else if (inst_valid_in && m_hz) m_state = M_STALL;
        else if (nxt_iv && !issue_ready) m_state = M_HOLD;
        else                            m_state = M_RUN;
        if (wb_valid) m_busy[wb_dest] = 1'b0;
        if (m_acc) begin
            if (writes(op)) m_busy[dest_in] = 1'b1;
            m_op   = op;
            m_s1   = reads_s1(op) ? int'(s1_in) : 0;
            m_s2   = reads_s2(op) ? int'(s2_in) : 0;
            m_dest = int'(dest_in);
            m_imm  = ime_data_in;
        end
        m_iv = nxt_iv;
        #1;
        if (chk) check_regs();
    endtask

    task automatic drive(input bit v, input int op, input int a, input int b, input int d,
                         input logic [31:0] imm);
        inst_valid_in = v;
        opcode_in     = op[4:0];
        s1_in         = a[3:0];
        s2_in         = b[3:0];
        dest_in       = d[3:0];
        ime_data_in   = imm;
    endtask

    initial begin
        model_reset();
        #12;
        check_regs();
        check("reset_state", {30'd0, dut.r_state}, M_RUN);
        rst_n = 1'b1;
        @(posedge clk); #1;
        issue_ready = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        cycle(1);
        check("ready_after_reset", {31'd0, inst_ready_out}, 32'd1);

        // RAW stall on r5, released by a writeback pulse
        drive(1, 2, 1, 2, 5, 32'h1111_0001);
        cycle(1);
        drive(1, 3, 5, 0, 8, 32'h2222_0002);
        for (int i = 0; i < 3; i++) begin
            cycle(1);
            check("raw_ready_low", {31'd0, inst_ready_out}, 32'd0);
        end
        check("raw_state", {30'd0, dut.r_state}, M_STALL);
        wb_valid = 1'b1; wb_dest = 4'd5;
        cycle(1);
        check("raw_wb_clear", {31'd0, busy_map[5]}, 32'd0);
        wb_valid = 1'b0;
        cycle(1);
        check("raw_accept_op", {27'd0, opcode_out}, 32'd3);
        check("raw_stall_cnt", {16'd0, stall_cnt}, 32'd4);
        drive(0, 0, 0, 0, 0, 0);
        cycle(1);

        // Unused s2 field must not stall on a busy register
        drive(1, 1, 0, 0, 7, 32'h0000_0007);
        cycle(1);
        drive(1, 1, 3, 7, 4, 32'h0000_0033);
        cycle(1);
        check("unused_s1", {28'd0, s1_out}, 32'd3);
        check("unused_s2", {28'd0, s2_out}, 32'd0);
        check("unused_busy4", {31'd0, busy_map[4]}, 32'd1);

        // Same-cycle set and clear on r6
        drive(1, 9, 0, 0, 6, 32'h0000_0066);
        wb_valid = 1'b1; wb_dest = 4'd6;
        cycle(1);
        wb_valid = 1'b0;
        check("set_wins", {31'd0, busy_map[6]}, 32'd1);

        // Backpressure: hold A for three cycles, then hand off and take B
        drive(1, 12, 0, 0, 0, 32'hAAAA_AAAA);
        cycle(1);
        issue_ready = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cycle(1);
            check("bp_hold_data", ime_data_out, 32'hAAAA_AAAA);
            check("bp_state", {30'd0, dut.r_state}, M_HOLD);
        end
        issue_ready = 1'b1;
        drive(1, 13, 0, 0, 0, 32'hBBBB_BBBB);
        cycle(1);
        check("bp_b_out", ime_data_out, 32'hBBBB_BBBB);
        drive(0, 0, 0, 0, 0, 0);
        cycle(1);

        // Flush with a writer to r9 held in the output register
        drive(1, 5, 0, 1, 9, 32'h0000_0099);
        cycle(1);
        issue_ready = 1'b0;
        drive(1, 12, 0, 0, 0, 32'h0000_00FF);
        flush = 1'b1;
        cycle(1);
        flush = 1'b0;
        check("flush_iv", {31'd0, issue_valid}, 32'd0);
        check("flush_busy9", {31'd0, busy_map[9]}, 32'd1);
        issue_ready = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        for (int r = 0; r < 16; r++) begin
            wb_valid = 1'b1; wb_dest = r[3:0];
            cycle(1);
        end
        wb_valid = 1'b0;

        // Random traffic against the model
        for (int n = 0; n < 600; n++) begin
            int pend;
            drive($urandom_range(99) < 70, $urandom_range(31), $urandom_range(7),
                  $urandom_range(7), $urandom_range(7), $urandom);
            issue_ready = $urandom_range(99) < 70;
            flush       = $urandom_range(99) < 5;
            wb_valid    = $urandom_range(99) < 35;
            pend = $urandom_range(15);
            for (int k = 0; k < 16; k++)
                if (m_busy[(pend + k) % 16]) begin
                    pend = (pend + k) % 16;
                    break;
                end
            wb_dest = pend[3:0];
            cycle(1);
        end
        flush = 1'b0; wb_valid = 1'b0; issue_ready = 1'b1;

        // Asynchronous reset in the middle of a stall
        drive(1, 8, 0, 0, 11, 32'h0000_00BB);
        cycle(1);
        drive(1, 8, 11, 0, 12, 32'h0000_00CC);
        cycle(1);
        cycle(1);
        check("pre_reset_state", {30'd0, dut.r_state}, M_STALL);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_regs();
        check("reset_state_mid", {30'd0, dut.r_state}, M_RUN);
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        cycle(1);

        // Saturation of the stall counter
        drive(1, 7, 0, 0, 10, 32'h0000_0010);
        cycle(1);
        drive(1, 7, 10, 0, 13, 32'h0000_0013);
        for (int i = 0; i < 65540; i++) cycle(0);
        cycle(1);
        check("stall_sat", {16'd0, stall_cnt}, 32'h0000_FFFF);
        cycle(1);
        check("stall_no_wrap", {16'd0, stall_cnt}, 32'h0000_FFFF);
        wb_valid = 1'b1; wb_dest = 4'd10;
        cycle(1);
        wb_valid = 1'b0;
        cycle(1);
        check("sat_release_op", {27'd0, opcode_out}, 32'd7);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_hazard_ctrl.md
FETCH_HAZARD_CTRL -- requirements
Module: fetch_hazard_ctrl

Interface
REQ-001 SHALL have ports, in order:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- inst_valid_in  in  1  fetched instruction present.
- inst_ready_out  out  1  instruction accepted this cycle when high with inst_valid_in.
- opcode_in  in  5  opcode.
- s1_in / s2_in / dest_in  in  4 each  register fields.
- ime_data_in  in  32  immediate.
- issue_valid  out  1  output register holds an instruction.
- issue_ready  in  1  downstream takes the instruction when high with issue_valid.
- opcode_out  out  5; s1_out / s2_out / dest_out  out  4 each; ime_data_out  out  32  registered instruction.
- wb_valid  in  1  writeback completing.
- wb_dest  in  4  register written back.
- flush  in  1  discard the held instruction and block acceptance this cycle.
- busy_map  out  16  scoreboard, bit n = register n has a pending writer.
- stall_cnt  out  16  saturating count of hazard-stall cycles.

Function
REQ-002 SHALL classify opcodes as follows:
- Reads s1 only: 00001, 00110-01011, 11011.
- Reads s1 and s2: 00010-00101, 11000, 11010, 11100, 11110.
- Reads nothing: all other opcodes (pass-through NOP).
REQ-003 SHALL treat opcodes 00001-01011 as writers of dest_in; no other opcode writes.
REQ-004 Hazard SHALL be asserted, while inst_valid_in is high, when any of these holds:
- s1 is read and busy_map[s1_in] is set;
- s2 is read and busy_map[s2_in] is set;
- the opcode is a writer and busy_map[dest_in] is set (WAW).
REQ-005 inst_ready_out = !hazard & !flush & (!issue_valid | issue_ready), combinational.
REQ-006 On accept, the output register SHALL load on the next edge (1-cycle latency):
- opcode_out, dest_out and ime_data_out are loaded unchanged.
- s1_out and s2_out are loaded as input when read, 0 when not read.
- issue_valid is set to 1.
REQ-007 issue_valid SHALL clear when issue_ready is high and no new accept occurs; with issue_ready low and no flush, the output register SHALL hold all values.
REQ-008 On an accept of a writer, busy_map[dest_in] SHALL set on the same edge.
REQ-009 On wb_valid, busy_map[wb_dest] SHALL clear on the same edge. There is no bypass: a consumer of wb_dest stalls in the wb_valid cycle and may be accepted the cycle after.
REQ-010 If a set and a clear target the same register in the same cycle, the set SHALL win.
REQ-011 A clear of an already-clear bit SHALL be a no-op.
REQ-012 flush SHALL clear issue_valid on the next edge. busy_map SHALL be unchanged, including the bit set by the flushed instruction (its writer still writes back).
REQ-013 FSM state SHALL be one of RUN, HOLD, STALL, with transitions on each edge:
- STALL: the next state when inst_valid_in & hazard; takes priority over HOLD.
- HOLD: the next state when issue_valid & !issue_ready after the edge.
- RUN: otherwise.
- flush SHALL force RUN.
REQ-014 stall_cnt SHALL increment by 1 each cycle the FSM is in STALL, saturating at 16'hFFFF with no wrap.
REQ-015 NOP opcodes SHALL never stall or set busy bits; they flow through with s1_out = s2_out = 0.

Reset
REQ-016 While rst_n is low, regardless of clk, the block SHALL hold:
- issue_valid = 0;
- opcode_out, s1_out, s2_out, dest_out, ime_data_out = 0;
- busy_map = 0;
- stall_cnt = 0;
- FSM = RUN.
REQ-017 Reset asserted mid-stall or mid-hold SHALL discard the held instruction and all pending scoreboard bits.
REQ-018 inst_ready_out SHALL be 1 in the first cycle after reset release when issue_ready is high.

Verification
REQ-019 SHALL cover the following directed scenarios:
- RAW stall: accept 00010 s1=1 s2=2 dest=5, then present 00011 s1=5 -> ready low, STALL. Pulse wb_valid wb_dest=5 -> busy_map[5] clears that edge; accept occurs the cycle after. stall_cnt equals the stall cycles.
- Unused field: present 00001 s1=3 s2=7 dest=4 with busy_map[7]=1 -> no stall; s1_out=3, s2_out=0, busy_map[4] sets.
- Same-register set and clear: wb_valid wb_dest=6 in the same cycle as accepting writer dest=6 -> busy_map[6]=1 afterwards.
- Backpressure: issue_ready=0 for 3 cycles with instruction A held -> outputs stable, FSM=HOLD. Release -> A handed off; next instruction B appears 1 cycle after its accept.
- Flush: flush with a writer dest=9 held -> issue_valid=0 next cycle, busy_map[9] still 1, inst_ready_out=0 during the flush cycle.
- Reset during STALL: assert rst_n=0 asynchronously -> all outputs 0 immediately. Saturation: force 65536+ stall cycles -> stall_cnt=16'hFFFF.
